// File: rtl/aes_pkg.sv
// aes_pkg: shared AES controller constants, state encoding and round-index type.
package aes_pkg;
    localparam int NR = 10;
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] rnd_idx_t;
    typedef enum logic [2:0] {IDLE, KEY_FWD, INIT_ADD, INV_RND, FINAL_RND, FINISH} state_t;
endpackage

// File: rtl/aes_rnd_counter.sv
// aes_rnd_counter: loadable up/down round counter with clear and terminal-count flag.
module aes_rnd_counter
    import aes_pkg::*;
(
    input  logic     CLK,
    input  logic     rst_n,
    input  logic     clr,
    input  logic     ld,
    input  logic     en,
    input  logic     up,
    input  rnd_idx_t ld_val,
    input  rnd_idx_t tc_val,
    output rnd_idx_t cnt,
    output logic     tc
);
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (ld) cnt <= ld_val;
        else if (en) cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
    end
    assign tc = cnt == tc_val;
endmodule

// File: rtl/aes_inv_ctrl_fsm.sv
// aes_inv_ctrl_fsm: AES-128 inverse cipher round controller with cached last round key.
module aes_inv_ctrl_fsm
    import aes_pkg::*;
(
    input  logic     CLK,
    input  logic     rst_n,
    input  logic     Valid,
    input  logic     New_Key,
    output logic     En_Exp,
    output logic     Ld_Last_Key,
    output logic     En_InvExp,
    output logic     Ld_Init,
    output logic     En_Func,
    output logic     Last_Rnd,
    output rnd_idx_t Rnd_Idx,
    output logic     Busy,
    output logic     Done
);
    state_t   state, nxt, go;
    logic     key_cached, tc;
    rnd_idx_t cnt, tc_val;
    assign go = !Valid ? IDLE : (New_Key || !key_cached) ? KEY_FWD : INIT_ADD;
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE, FINISH: nxt = go;
            KEY_FWD:      nxt = tc ? INIT_ADD : KEY_FWD;
            INIT_ADD:     nxt = INV_RND;
            INV_RND:      nxt = tc ? FINAL_RND : INV_RND;
            FINAL_RND:    nxt = FINISH;
            default:      nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            key_cached <= 1'b0;
        end else begin
            state <= nxt;
            if (Ld_Last_Key) key_cached <= 1'b1;
        end
    end
    // Counter restarts from 0 on every state change; INV_RND indexes count down from it.
    assign tc_val = state == KEY_FWD ? rnd_idx_t'(NR - 1) : rnd_idx_t'(NR - 2);
    aes_rnd_counter u_cnt (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .clr    (nxt != state),
        .ld     (1'b0),
        .en     (state == KEY_FWD || state == INV_RND),
        .up     (1'b1),
        .ld_val ('0),
        .tc_val (tc_val),
        .cnt    (cnt),
        .tc     (tc)
    );
    assign En_Exp      = state == KEY_FWD;
    assign Ld_Last_Key = En_Exp && tc;
    assign Ld_Init     = state == INIT_ADD;
    assign En_InvExp   = state == INV_RND || state == FINAL_RND;
    assign En_Func     = En_InvExp;
    assign Last_Rnd    = state == FINAL_RND;
    assign Busy        = En_Exp || Ld_Init || En_InvExp;
    assign Done        = state == FINISH;
    assign Rnd_Idx     = En_Exp ? cnt + 1'b1 :
                         Ld_Init ? rnd_idx_t'(NR) :
                         state == INV_RND ? rnd_idx_t'(NR - 1) - cnt : '0;
endmodule

// File: doc/aes_inv_ctrl_fsm.md
Name: aes_inv_ctrl_fsm

Overview:
- Control FSM for the AES-128 inverse cipher (decryption), the counterpart of the encryption round controller.
- Decryption consumes round keys 10→0. On a new key, the block first runs forward key expansion to obtain round key 10 and caches it. It then sequences the initial AddRoundKey, nine inverse rounds and the final inverse round, while driving the inverse key-expansion datapath.
- Sits between the top-level handshake (Valid/Busy/Done) and the inverse round / key-schedule datapath.

Parameters:
NR, 10, number of AES rounds (AES-128)
CNT_W, 4, width of round counter and Rnd_Idx

Ports:
CLK  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
Valid  input  1  start request; sampled only in IDLE or FINISH
New_Key  input  1  key input changed; sampled together with accepted Valid
En_Exp  output  1  forward key-expansion step enable
Ld_Last_Key  output  1  capture the forward-expanded round key 10 into the last-key register
En_InvExp  output  1  inverse key-expansion step enable
Ld_Init  output  1  load ciphertext XOR round key 10; load last-key register into the working key register
En_Func  output  1  inverse round (InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns) enable
Last_Rnd  output  1  bypass InvMixColumns for the current round
Rnd_Idx  output  CNT_W  index of the round key produced or consumed this cycle (Rcon select)
Busy  output  1  operation in progress
Done  output  1  plaintext valid, one-cycle pulse

Behaviour:
- Clock is CLK; reset is asynchronous, active-low rst_n. Reset forces state=IDLE, rnd_cnt=0, key_cached=0. All outputs are 0 during reset and in IDLE.
- States: IDLE, KEY_FWD, INIT_ADD, INV_RND, FINAL_RND, FINISH.
- Start decision, made in IDLE or FINISH when Valid=1:
  - If New_Key=1 or key_cached=0, go to KEY_FWD.
  - Otherwise go to INIT_ADD.
  - With Valid=0, go to IDLE.
- KEY_FWD: NR cycles, rnd_cnt counts 0..NR-1.
  - En_Exp=1, Busy=1, Rnd_Idx=rnd_cnt+1 (1..10).
  - On rnd_cnt=NR-1: Ld_Last_Key=1, key_cached←1, go to INIT_ADD, rnd_cnt←0.
- INIT_ADD: 1 cycle. Ld_Init=1, Busy=1, Rnd_Idx=10. Go to INV_RND.
- INV_RND: NR-1 cycles.
  - En_Func=1, En_InvExp=1, Busy=1.
  - Rnd_Idx counts NR-1 down to 1 (9..1).
  - After the cycle with Rnd_Idx=1, go to FINAL_RND.
- FINAL_RND: 1 cycle. En_Func=1, Last_Rnd=1, En_InvExp=1, Busy=1, Rnd_Idx=0. Go to FINISH.
- FINISH: Done=1, Busy=0. Applies the same start decision as IDLE, so back-to-back blocks run with no idle gap.
- Latency, Valid accepted at edge t:
  - Cached key: INIT_ADD at t+1, INV_RND t+2..t+10, FINAL_RND t+11, Done high in cycle t+12.
  - New key: +NR, so Done at t+22.
- Valid and New_Key are ignored while Busy=1. New_Key does not clear key_cached mid-operation; it takes effect only with the next accepted Valid.
- rnd_cnt is cleared on every state transition. It never wraps inside a state, because exit happens at its terminal value.
- Unused or illegal state encodings go to IDLE with all outputs 0.
- Reset asserted mid-operation:
  - Immediate return to IDLE, Busy=0, Done=0, key_cached=0.
  - The next Valid therefore always re-runs KEY_FWD.
- Outputs are decoded combinationally from state and rnd_cnt only; there is no Valid→output combinational path.

Decomposition:
- Shared package aes_pkg:
  - state enum (IDLE, KEY_FWD, INIT_ADD, INV_RND, FINAL_RND, FINISH), 3-bit encoding.
  - NR constant.
  - Rnd_Idx type (logic [CNT_W-1:0]).
- Natural sub-module: aes_rnd_counter. It is a loadable up/down counter with clear, terminal-count flag and direction select, and is reusable by the encryption controller.
- The FSM next-state and output logic stay in aes_inv_ctrl_fsm.

Test Plan:
- Reset, then Valid=1, New_Key=1 for 1 cycle:
  - En_Exp high 10 cycles with Rnd_Idx 1..10, Ld_Last_Key on the 10th.
  - Then Ld_Init with Rnd_Idx=10, 9 En_Func cycles with Rnd_Idx 9..1, Last_Rnd with Rnd_Idx=0.
  - Done pulses at t+22; Busy high t+1..t+21.
- Second Valid=1, New_Key=0 after Done, cached key: no En_Exp; Ld_Init at t+1; Done at t+12.
- Valid held high continuously with New_Key=0: FINISH goes directly to INIT_ADD. Done pulses every 12 cycles, with Busy low only in the Done cycle.
- Valid and New_Key toggled during INV_RND: no effect on sequence or timing. Done still at t+12; key_cached stays 1.
- rst_n asserted during INV_RND (Rnd_Idx=5): outputs 0 asynchronously. After release, Valid with New_Key=0 still runs 10 KEY_FWD cycles (Done at t+22).
- Valid=0 after FINISH: returns to IDLE with all outputs 0; Done stays low indefinitely.
